tia_horizontal_motion_controller: RTL and testbench
===================================================

# tia_horizontal_motion_controller

Sequences the TIA horizontal-motion (HMOVE) operation for the five movable objects (player 0/1, missile 0/1, ball). Holds the five 4-bit signed motion registers, arms on an HMOVE strobe, and at the next line start issues a burst of extra-clock enables to each object's position counter: these drive the `pxec_bar`/`mxec_bar` inputs of the player-graphics blocks and the ball's equivalent. It also generates the extended horizontal-blank flag that masks the line's first 8 colour clocks.

## Interface
- No parameters.
- `clk` in 1: colour clock; all state updates on rising edge.
- `reset_bar` in 1: asynchronous, active-low reset.
- `d4`..`d7` in 1 each: data bus bits; `d7..d4` is a two's-complement motion value, range -8..+7.
- `hmp0`, `hmp1`, `hmm0`, `hmm1`, `hmbl` in 1 each: one-clk write strobes; latch `d7..d4` into the matching motion register.
- `hmclr` in 1: one-clk strobe; clears all five motion registers to 0.
- `hmove` in 1: one-clk strobe; arms a motion sequence.
- `line_start` in 1: one-clk pulse at the start of horizontal blank.
- `p0ec_bar`, `p1ec_bar`, `m0ec_bar`, `m1ec_bar`, `blec_bar` out 1 each: extra-clock enables, active low.
- `hmove_blank` out 1: extended-hblank flag.
- `busy` out 1: high while a sequence is running.

## Operation
- **Motion registers**
  - Five 4-bit registers; reset value 0.
  - A write strobe loads `d7..d4` at the clock edge.
  - `hmclr` has priority over a simultaneous write strobe.
- **Extra-clock count**
  - Per object: `n = m + 8`, computed unsigned in 0..15 by inverting bit 3 of `m`.
  - Motion 0 gives 8 extra clocks, which cancels the 8 masked blank clocks.
- **State machine**
  - States: IDLE, ARMED, RUN.
  - IDLE -> ARMED on `hmove`.
  - ARMED -> RUN on `line_start`.
  - RUN -> IDLE after slot 15 phase 3, unless ARMED was re-requested (see rules below).
- **RUN state**
  - 4-bit slot counter `s` (0..15) and 2-bit phase counter `ph` (0..3).
  - `ph` increments every clk; `s` increments when `ph` wraps.
  - At `ph == 0`, each object's `*ec_bar` is driven low for exactly one clk if `s < n`, using that object's current register value.
- **Boundary rules**
  - A motion write during RUN takes effect from the next `ph == 0` comparison.
  - `hmove` during RUN sets a pending flag; the current sequence completes, then the state returns to ARMED instead of IDLE.
  - `line_start` during RUN with pending set: restart immediately with `s = 0`, `ph = 0`, pending cleared.
  - `line_start` during RUN without pending: ignored.
  - `hmove` and `line_start` in the same cycle from IDLE: enter ARMED only; RUN starts at the following `line_start`.
  - Reset mid-sequence: all `*ec_bar` go to 1 immediately; `hmove_blank` = 0, `busy` = 0; state IDLE; pending cleared.

## Timing
- Reset values: all `*ec_bar` = 1, `hmove_blank` = 0, `busy` = 0, motion registers = 0.
- `line_start` seen in ARMED at edge t: RUN begins at t+1 with `s = 0`, `ph = 0`.
- Enable pulses for slot k occur in cycle t+1+4k, for k < n.
- `busy` is high for cycles t+1..t+64 inclusive (64 clks).
- `hmove_blank` is high for cycles t+1..t+8.
- All outputs are registered; no combinational path from any input to any output.
- Write-strobe latency: a register written at edge w is used by a comparison at edge w+1 or later.

## Configuration
- `TIA_HMOVE_BLANK_EN`
  - Defined: `hmove_blank` is generated as specified.
  - Undefined: `hmove_blank` is tied to 0 and its counter logic is removed; `*ec_bar` behaviour is unchanged.

## Structure
- Package `tia_hmove_pkg` holds:
  - constants `SLOT_CLOCKS = 4`, `SLOT_COUNT = 16`, `BLANK_CLOCKS = 8`;
  - state encoding IDLE/ARMED/RUN;
  - object index constants P0, P1, M0, M1, BL.
- Sub-module `tia_hmove_object_comparator`, instantiated five times. Each instance:
  - holds one motion register;
  - computes `n`;
  - produces its registered `*ec_bar` from `s`, `ph == 0`, and the RUN flag.

## Test plan
- Reset, write `hmp0` = 0x0, `hmove`, `line_start` -> exactly 8 `p0ec_bar` low pulses, 4 clks apart; `busy` high 64 clks; `hmove_blank` high 8 clks.
- `hmp1` = 0x7 (+7), `hmbl` = 0x8 (-8) -> 15 pulses on `p1ec_bar`, 0 on `blec_bar`; the other three objects give 8 each.
- `hmclr` asserted together with an `hmm0` = 0x5 write, then a sequence -> `m0ec_bar` gives 8 pulses (clear wins).
- During RUN, write `hmm1` = 0x7 at slot 3 -> `m1ec_bar` pulses continue through slot 14 (15 total).
- `hmove` during RUN, then `line_start` at slot 10 -> sequence restarts at `s = 0`; pulse counts restart; `busy` remains high.
- Reset asserted at slot 5 -> outputs return to reset values asynchronously; a following `line_start` without `hmove` produces no pulses.

Source files
------------

// File: rtl/tia_hmove_pkg.sv
// Shared constants, state encoding and object indices for the TIA HMOVE controller.
package tia_hmove_pkg;

  localparam int SLOT_CLOCKS  = 4;
  localparam int SLOT_COUNT   = 16;
  localparam int BLANK_CLOCKS = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int M0 = 2;
  localparam int M1 = 3;
  localparam int BL = 4;
  localparam int NUM_OBJECTS = 5;

  // Signed motion -8..+7 maps to 0..15 extra clocks by flipping the sign bit.
  function automatic logic [3:0] extra_clocks(input logic [3:0] motion);
    return {~motion[3], motion[2:0]};
  endfunction

endpackage

// File: rtl/tia_hmove_object_comparator.sv
// One movable object's motion register and its registered extra-clock enable.
module tia_hmove_object_comparator
  import tia_hmove_pkg::*;
(
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] data,
  input  logic       run,
  input  logic       phase_zero,
  input  logic [3:0] slot,
  output logic       ec_bar
);

  logic [3:0] motion;
  logic [3:0] count;

  assign count = extra_clocks(motion);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)
      motion <= '0;
    else if (clear)
      motion <= '0;
    else if (load)
      motion <= data;
  end

  // The comparison uses the register value held before this edge, so a write lands one slot check later.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)
      ec_bar <= 1'b1;
    else
      ec_bar <= !(run && phase_zero && (slot < count));
  end

endmodule

// File: rtl/tia_horizontal_motion_controller.sv
// TIA HMOVE sequencer: arms on hmove, bursts extra-clock enables per object after line_start.
// Optional macro TIA_HMOVE_BLANK_EN enables the extended-hblank flag; otherwise hmove_blank is tied low.
module tia_horizontal_motion_controller
  import tia_hmove_pkg::*;
(
  input  logic clk,
  input  logic reset_bar,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic hmp0,
  input  logic hmp1,
  input  logic hmm0,
  input  logic hmm1,
  input  logic hmbl,
  input  logic hmclr,
  input  logic hmove,
  input  logic line_start,
  output logic p0ec_bar,
  output logic p1ec_bar,
  output logic m0ec_bar,
  output logic m1ec_bar,
  output logic blec_bar,
  output logic hmove_blank,
  output logic busy
);

  logic [1:0] state, state_nx;
  logic [3:0] slot, slot_nx;
  logic [1:0] phase, phase_nx;
  logic       pending, pending_nx;
  logic       run_nx;
  logic       phase_zero_nx;
  logic [3:0] data;
  logic [NUM_OBJECTS-1:0] load;
  logic [NUM_OBJECTS-1:0] ec_bar_vec;

  assign data = {d7, d6, d5, d4};
  assign load = {hmbl, hmm1, hmm0, hmp1, hmp0};

  always_comb begin
    state_nx   = state;
    slot_nx    = slot;
    phase_nx   = phase;
    pending_nx = pending;
    case (state)
      IDLE: begin
        if (hmove)
          state_nx = ARMED;
      end
      ARMED: begin
        if (line_start) begin
          state_nx = RUN;
          slot_nx  = '0;
          phase_nx = '0;
        end
      end
      RUN: begin
        pending_nx = pending | hmove;
        // A pending re-arm lets the next line_start restart the burst from slot 0.
        if (line_start && pending) begin
          slot_nx    = '0;
          phase_nx   = '0;
          pending_nx = 1'b0;
        end else if (slot == 4'(SLOT_COUNT - 1) && phase == 2'(SLOT_CLOCKS - 1)) begin
          state_nx   = pending_nx ? ARMED : IDLE;
          pending_nx = 1'b0;
        end else begin
          phase_nx = phase + 2'd1;
          if (phase == 2'(SLOT_CLOCKS - 1))
            slot_nx = slot + 4'd1;
        end
      end
      default: begin
        state_nx   = IDLE;
        pending_nx = 1'b0;
      end
    endcase
  end

  assign run_nx        = (state_nx == RUN);
  assign phase_zero_nx = (phase_nx == 2'd0);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state   <= IDLE;
      slot    <= '0;
      phase   <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      slot    <= slot_nx;
      phase   <= phase_nx;
      pending <= pending_nx;
      busy    <= run_nx;
    end
  end

`ifdef TIA_HMOVE_BLANK_EN
  // Blank covers the first BLANK_CLOCKS positions of the burst, i.e. slots 0 and 1.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)
      hmove_blank <= 1'b0;
    else
      hmove_blank <= run_nx && ({slot_nx, phase_nx} < 6'(BLANK_CLOCKS));
  end
`else
  assign hmove_blank = 1'b0;
`endif

  for (genvar i = 0; i < NUM_OBJECTS; i++) begin : g_obj
    tia_hmove_object_comparator u_cmp (
      .clk        (clk),
      .reset_bar  (reset_bar),
      .load       (load[i]),
      .clear      (hmclr),
      .data       (data),
      .run        (run_nx),
      .phase_zero (phase_zero_nx),
      .slot       (slot_nx),
      .ec_bar     (ec_bar_vec[i])
    );
  end

  assign p0ec_bar = ec_bar_vec[P0];
  assign p1ec_bar = ec_bar_vec[P1];
  assign m0ec_bar = ec_bar_vec[M0];
  assign m1ec_bar = ec_bar_vec[M1];
  assign blec_bar = ec_bar_vec[BL];

endmodule

// File: tb/tb_tia_horizontal_motion_controller.sv
// Self-checking bench for tia_horizontal_motion_controller: position-based model plus directed pulse-count checks.
`timescale 1ns/1ps
module tb_tia_horizontal_motion_controller;

  logic clk = 1'b0;
  logic reset_bar = 1'b0;
  logic d4 = 1'b0, d5 = 1'b0, d6 = 1'b0, d7 = 1'b0;
  logic hmp0 = 1'b0, hmp1 = 1'b0, hmm0 = 1'b0, hmm1 = 1'b0, hmbl = 1'b0;
  logic hmclr = 1'b0, hmove = 1'b0, line_start = 1'b0;
  logic p0ec_bar, p1ec_bar, m0ec_bar, m1ec_bar, blec_bar, hmove_blank, busy;

`ifdef TIA_HMOVE_BLANK_EN
  localparam int BLANK_RUN = 8;
`else
  localparam int BLANK_RUN = 0;
`endif

  always #5 clk = ~clk;

  tia_horizontal_motion_controller dut (
    .clk         (clk),
    .reset_bar   (reset_bar),
    .d4          (d4),
    .d5          (d5),
    .d6          (d6),
    .d7          (d7),
    .hmp0        (hmp0),
    .hmp1        (hmp1),
    .hmm0        (hmm0),
    .hmm1        (hmm1),
    .hmbl        (hmbl),
    .hmclr       (hmclr),
    .hmove       (hmove),
    .line_start  (line_start),
    .p0ec_bar    (p0ec_bar),
    .p1ec_bar    (p1ec_bar),
    .m0ec_bar    (m0ec_bar),
    .m1ec_bar    (m1ec_bar),
    .blec_bar    (blec_bar),
    .hmove_blank (hmove_blank),
    .busy        (busy)
  );

  int checks = 0;
  int fails  = 0;

  // Model: run_pos is the clock position within the 64-clock burst, -1 when not running.
  int   motion[5];
  bit   armed   = 1'b0;
  bit   pending = 1'b0;
  int   run_pos = -1;
  logic exp_busy  = 1'b0;
  logic exp_blank = 1'b0;
  logic [4:0] exp_ec = 5'h1f;

  int pulse_cnt[5];
  int busy_cnt  = 0;
  int blank_cnt = 0;

  logic [4:0] dut_ec;
  logic [4:0] strobe_vec;
  assign dut_ec     = {blec_bar, m1ec_bar, m0ec_bar, p1ec_bar, p0ec_bar};
  assign strobe_vec = {hmbl, hmm1, hmm0, hmp1, hmp0};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      armed   = 1'b0;
      pending = 1'b0;
      run_pos = -1;
      foreach (motion[i]) motion[i] = 0;
      exp_busy  = 1'b0;
      exp_blank = 1'b0;
      exp_ec    = 5'h1f;
    end else begin
      bit restart;
      logic signed [3:0] dv;
      restart = line_start && pending;
      dv = {d7, d6, d5, d4};
      if (run_pos >= 0) begin
        if (hmove) pending = 1'b1;
        if (restart) begin
          run_pos = 0;
          pending = 1'b0;
        end else if (run_pos == 63) begin
          run_pos = -1;
          armed   = pending;
          pending = 1'b0;
        end else begin
          run_pos++;
        end
      end else if (armed) begin
        if (line_start) begin
          run_pos = 0;
          armed   = 1'b0;
        end
      end else if (hmove) begin
        armed = 1'b1;
      end
      exp_busy  = (run_pos >= 0);
      exp_blank = (run_pos >= 0 && run_pos < BLANK_RUN);
      for (int i = 0; i < 5; i++)
        exp_ec[i] = !(run_pos >= 0 && (run_pos % 4) == 0 && (run_pos / 4) < motion[i] + 8);
      if (hmclr) begin
        foreach (motion[i]) motion[i] = 0;
      end else begin
        for (int i = 0; i < 5; i++)
          if (strobe_vec[i]) motion[i] = int'(dv);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", busy, exp_busy);
    checkOutput("hmove_blank", hmove_blank, exp_blank);
    checkOutput("ec_bar_vec", dut_ec, exp_ec);
    for (int i = 0; i < 5; i++)
      if (!dut_ec[i]) pulse_cnt[i]++;
    if (busy) busy_cnt++;
    if (hmove_blank) blank_cnt++;
  end

  task automatic applyStimulus(input logic [4:0] hm, input logic [3:0] dval,
                               input logic clr, input logic hmv, input logic ls);
    {hmbl, hmm1, hmm0, hmp1, hmp0} = hm;
    {d7, d6, d5, d4} = dval;
    hmclr = clr;
    hmove = hmv;
    line_start = ls;
    @(negedge clk);
    {hmbl, hmm1, hmm0, hmp1, hmp0} = 5'b0;
    {d7, d6, d5, d4} = 4'h0;
    hmclr = 1'b0;
    hmove = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    foreach (pulse_cnt[i]) pulse_cnt[i] = 0;
    busy_cnt  = 0;
    blank_cnt = 0;
  endtask

  task automatic check_counts(input string tag, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int eb, input int ebl);
    checkOutput({tag, "_p0_pulses"}, pulse_cnt[0], e0);
    checkOutput({tag, "_p1_pulses"}, pulse_cnt[1], e1);
    checkOutput({tag, "_m0_pulses"}, pulse_cnt[2], e2);
    checkOutput({tag, "_m1_pulses"}, pulse_cnt[3], e3);
    checkOutput({tag, "_bl_pulses"}, pulse_cnt[4], e4);
    checkOutput({tag, "_busy_clks"}, busy_cnt, eb);
    checkOutput({tag, "_blank_clks"}, blank_cnt, ebl);
  endtask

  initial begin
    clear_counts();
    tick(2);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_blank", hmove_blank, 0);
    checkOutput("reset_ec", dut_ec, 5'h1f);
    reset_bar = 1'b1;
    tick(1);

    $display("[TB] motion 0 on p0, plain sequence");
    applyStimulus(5'b00001, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    clear_counts();
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("first_clk_busy", busy, 1);
    checkOutput("first_clk_p0", p0ec_bar, 0);
    tick(3);
    checkOutput("pos3_p0", p0ec_bar, 1);
    tick(1);
    checkOutput("pos4_p0", p0ec_bar, 0);
    tick(70);
    check_counts("plain", 8, 8, 8, 8, 8, 64, BLANK_RUN);

    $display("[TB] p1=+7, bl=-8, hmove with line_start from idle");
    applyStimulus(5'b00010, 4'h7, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b10000, 4'h8, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b1);
    tick(5);
    checkOutput("same_cycle_arm_busy", busy, 0);
    clear_counts();
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(70);
    check_counts("extremes", 8, 15, 8, 8, 0, 64, BLANK_RUN);

    $display("[TB] hmclr wins over hmm0 write");
    applyStimulus(5'b00100, 4'h5, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    clear_counts();
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(70);
    check_counts("clear", 8, 8, 8, 8, 8, 64, BLANK_RUN);

    $display("[TB] hmm1=+7 written at slot 3 during run");
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    clear_counts();
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(12);
    applyStimulus(5'b01000, 4'h7, 1'b0, 1'b0, 1'b0);
    tick(70);
    check_counts("midrun_write", 8, 8, 8, 15, 8, 64, BLANK_RUN);

    $display("[TB] re-arm during run, restart at slot 10");
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    clear_counts();
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(4);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(35);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_p0", p0ec_bar, 0);
    tick(70);
    check_counts("restart", 16, 16, 16, 26, 16, 105, 2 * BLANK_RUN);

    $display("[TB] reset at slot 5");
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(20);
    #2 reset_bar = 1'b0;
    #1;
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_blank", hmove_blank, 0);
    checkOutput("async_reset_ec", dut_ec, 5'h1f);
    @(negedge clk);
    reset_bar = 1'b1;
    tick(1);
    clear_counts();
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(70);
    check_counts("after_reset_no_arm", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'b00000, 4'h0, 1'b0, 1'b0, 1'b1);
    tick(70);
    check_counts("after_reset_regs", 8, 8, 8, 8, 8, 64, BLANK_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
